// File: rtl/envelope_shaper_if.sv
// Sample-stream bundle between note player, envelope shaper and codec.
// master drives notes and samples in; slave is the shaper.
interface envelope_shaper_if;
   logic        play_enable;
   logic        note_start;
   logic        note_done;
   logic [15:0] sample_in;
   logic        sample_in_ready;
   logic [15:0] sample_out;
   logic        sample_out_ready;
   logic [7:0]  envelope;
   logic [2:0]  env_state;

   modport master (
      output play_enable, note_start, note_done,
      output sample_in, sample_in_ready,
      input  sample_out, sample_out_ready,
      input  envelope, env_state
   );

   modport slave (
      input  play_enable, note_start, note_done,
      input  sample_in, sample_in_ready,
      output sample_out, sample_out_ready,
      output envelope, env_state
   );
endinterface

// File: rtl/envelope_shaper.sv
// Per-note ADSR gain with a two-stage registered sample scaler.
// Everything freezes while play_enable is low.
module envelope_shaper #(
   parameter int ATTACK_STEP   = 8,
   parameter int DECAY_STEP    = 2,
   parameter int SUSTAIN_LEVEL = 192,
   parameter int RELEASE_STEP  = 4
) (
   input logic         clk,
   input logic         reset,
   envelope_shaper_if.slave bus
);

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] ATTACK  = 3'd1;
   localparam logic [2:0] DECAY   = 3'd2;
   localparam logic [2:0] SUSTAIN = 3'd3;
   localparam logic [2:0] RELEASE = 3'd4;

   logic [2:0]  state, state_n;
   logic [7:0]  gain, gain_n;
   logic        done_q;
   logic        s1_valid;
   logic [15:0] s1_sample;
   logic [7:0]  s1_gain;
   logic [15:0] out_q;
   logic        out_rdy_q;

   logic        en, tick, done_edge, in_note;
   logic [9:0]  atk_sum, dec_lim, rel_lim, gain_w;

   assign en        = bus.play_enable;
   assign tick      = bus.sample_in_ready & en;
   assign done_edge = bus.note_done & ~done_q;
   assign in_note   = (state == ATTACK) || (state == DECAY) ||
                      (state == SUSTAIN);

   assign gain_w  = {2'b00, gain};
   assign atk_sum = gain_w + 10'(ATTACK_STEP);
   assign dec_lim = 10'(SUSTAIN_LEVEL) + 10'(DECAY_STEP);
   assign rel_lim = 10'(RELEASE_STEP);

   always_comb begin
      state_n = state;
      gain_n  = gain;
      if (bus.note_start) begin
         state_n = ATTACK;
      end else if (done_edge && in_note) begin
         state_n = RELEASE;
      end else if (tick) begin
         case (state)
            ATTACK: begin
               if (atk_sum >= 10'd255) begin
                  gain_n  = 8'd255;
                  state_n = DECAY;
               end else begin
                  gain_n = atk_sum[7:0];
               end
            end
            DECAY: begin
               if (gain_w <= dec_lim) begin
                  gain_n  = 8'(SUSTAIN_LEVEL);
                  state_n = SUSTAIN;
               end else begin
                  gain_n = gain - 8'(DECAY_STEP);
               end
            end
            RELEASE: begin
               if (gain_w <= rel_lim) begin
                  gain_n  = 8'd0;
                  state_n = IDLE;
               end else begin
                  gain_n = gain - 8'(RELEASE_STEP);
               end
            end
            IDLE:    gain_n = 8'd0;
            default: gain_n = gain;
         endcase
      end
   end

   // gain is at most 255, so bits [23:8] of the product never overflow
   logic signed [23:0] samp_ext, gain_ext, product;
   logic               prod_unused;

   assign samp_ext    = {{8{s1_sample[15]}}, s1_sample};
   assign gain_ext    = {16'd0, s1_gain};
   assign product     = samp_ext * gain_ext;
   assign prod_unused = ^product[7:0];

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         gain      <= 8'd0;
         done_q    <= 1'b0;
         s1_valid  <= 1'b0;
         s1_sample <= 16'd0;
         s1_gain   <= 8'd0;
         out_q     <= 16'd0;
         out_rdy_q <= 1'b0;
      end else if (en) begin
         state    <= state_n;
         gain     <= gain_n;
         done_q   <= bus.note_done;
         s1_valid <= tick;
         if (tick) begin
            s1_sample <= bus.sample_in;
            s1_gain   <= gain;
         end
         out_rdy_q <= s1_valid;
         if (s1_valid) out_q <= product[23:8];
      end else begin
         // a pending sample stays in stage 1; only the pulse is withheld
         out_rdy_q <= 1'b0;
      end
   end

   assign bus.sample_out       = out_q;
   assign bus.sample_out_ready = out_rdy_q;
   assign bus.envelope         = gain;
   assign bus.env_state        = state;

endmodule

// File: tb/tb_envelope_shaper.sv
// Directed plus random stimulus for envelope_shaper against an
// arithmetic ADSR model; a second instance covers the gain-1 case.
module tb_envelope_shaper;

   localparam int AS = 8, DS = 2, SL = 192, RS = 4;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic reset1 = 1'b1;
   always #5 clk = ~clk;

   envelope_shaper_if bus ();
   envelope_shaper_if bus1 ();

   envelope_shaper dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   envelope_shaper #(.ATTACK_STEP(1)) dut1 (
      .clk   (clk),
      .reset (reset1),
      .bus   (bus1.slave)
   );

   int total = 0;
   int bad = 0;

   // model: 0 idle,1 attack,2 decay,3 sustain,4 release
   int m_st, m_g, m_out, m_rdy, m_pend, m_pv, m_dq;

   function automatic int scale(int s, int g);
      int p;
      p = s * g;
      if (p >= 0) return p / 256;
      return -((-p + 255) / 256);
   endfunction

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_edge();
      int s;
      bit edge_d, tk;
      if (reset) begin
         m_st = 0; m_g = 0; m_out = 0; m_rdy = 0;
         m_pend = 0; m_pv = 0; m_dq = 0;
      end else if (!bus.play_enable) begin
         m_rdy = 0;
      end else begin
         tk = bus.sample_in_ready;
         m_rdy = m_pend;
         if (m_pend != 0) m_out = m_pv;
         m_pend = tk;
         s = $signed(bus.sample_in);
         if (tk) m_pv = scale(s, m_g);
         edge_d = bus.note_done && (m_dq == 0);
         m_dq = bus.note_done;
         if (bus.note_start) m_st = 1;
         else if (edge_d && m_st >= 1 && m_st <= 3) m_st = 4;
         else if (tk) begin
            if (m_st == 1) begin
               if (m_g + AS >= 255) begin m_g = 255; m_st = 2; end
               else m_g += AS;
            end else if (m_st == 2) begin
               if (m_g - DS <= SL) begin m_g = SL; m_st = 3; end
               else m_g -= DS;
            end else if (m_st == 4) begin
               if (m_g <= RS) begin m_g = 0; m_st = 0; end
               else m_g -= RS;
            end
         end
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      model_edge();
      #1;
      check("rdy", 32'(bus.sample_out_ready), 32'(m_rdy[0]));
      check("out", 32'(bus.sample_out), 32'(m_out[15:0]));
      check("env", 32'(bus.envelope), 32'(m_g));
      check("state", 32'(bus.env_state), 32'(m_st));
   endtask

   task automatic set_in(bit p, bit s, bit t, logic [15:0] x);
      bus.play_enable     = p;
      bus.note_start      = s;
      bus.sample_in_ready = t;
      bus.sample_in       = x;
   endtask

   task automatic ticks(int n);
      for (int i = 0; i < n; i++) begin
         set_in(1, 0, 1, 16'($urandom));
         cyc();
      end
   endtask

   task automatic step1();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int npulse;
      bus.note_done = 1'b0;
      set_in(1, 0, 0, 16'h0);
      bus1.play_enable = 1'b1;
      bus1.note_start = 1'b0;
      bus1.note_done = 1'b0;
      bus1.sample_in = 16'h0;
      bus1.sample_in_ready = 1'b0;

      cyc();
      cyc();
      check("rst_state", 32'(bus.env_state), 32'd0);
      check("rst_rdy", 32'(bus.sample_out_ready), 32'd0);
      reset = 1'b0;

      // idle ticks keep the codec fed with zeros
      npulse = 0;
      for (int i = 0; i < 7; i++) begin
         set_in(1, 0, i < 5, 16'h4000);
         cyc();
         npulse += int'(bus.sample_out_ready);
         check("idle_out", 32'(bus.sample_out), 32'd0);
      end
      check("idle_pulses", npulse, 32'd5);

      set_in(1, 1, 0, 16'h0);
      cyc();
      check("atk_start", 32'(bus.env_state), 32'd1);
      for (int i = 1; i <= 31; i++) begin
         ticks(1);
         check("atk_gain", 32'(bus.envelope), 32'(8 * i));
      end
      ticks(1);
      check("atk_top", 32'(bus.envelope), 32'd255);
      check("to_decay", 32'(bus.env_state), 32'd2);
      set_in(1, 0, 1, 16'hC000);
      cyc();
      ticks(1);
      check("scale_neg", 32'(bus.sample_out), 32'h0000C040);
      ticks(29);
      check("decay_193", 32'(bus.envelope), 32'd193);
      ticks(1);
      check("sus_gain", 32'(bus.envelope), 32'd192);
      check("sus_state", 32'(bus.env_state), 32'd3);
      set_in(1, 0, 1, 16'h4000);
      cyc();
      set_in(1, 0, 0, 16'h0);
      cyc();
      check("sus_scale", 32'(bus.sample_out), 32'h00003000);
      check("sus_rdy", 32'(bus.sample_out_ready), 32'd1);

      // release, coincident tick must not step
      bus.note_done = 1'b1;
      set_in(1, 0, 1, 16'h1234);
      cyc();
      check("rel_state", 32'(bus.env_state), 32'd4);
      check("rel_hold", 32'(bus.envelope), 32'd192);
      ticks(48);
      check("rel_zero", 32'(bus.envelope), 32'd0);
      check("rel_idle", 32'(bus.env_state), 32'd0);
      ticks(5);
      check("no_rerel", 32'(bus.env_state), 32'd0);

      bus.note_done = 1'b0;
      set_in(1, 0, 0, 16'h0);
      cyc();
      set_in(1, 1, 0, 16'h0);
      cyc();
      ticks(64);
      check("sus2", 32'(bus.env_state), 32'd3);
      bus.note_done = 1'b1;
      set_in(1, 0, 0, 16'h0);
      cyc();
      ticks(23);
      check("rel_100", 32'(bus.envelope), 32'd100);
      set_in(1, 1, 1, 16'h0100);
      cyc();
      check("retrig_st", 32'(bus.env_state), 32'd1);
      check("retrig_g", 32'(bus.envelope), 32'd100);
      ticks(1);
      check("retrig_108", 32'(bus.envelope), 32'd108);

      bus.note_done = 1'b0;
      set_in(1, 0, 0, 16'h0);
      cyc();
      bus.note_done = 1'b1;
      set_in(1, 1, 1, 16'h0);
      cyc();
      check("prio", 32'(bus.env_state), 32'd1);

      // pause with a sample in flight and a done edge arriving
      bus.note_done = 1'b0;
      set_in(1, 0, 1, 16'h7777);
      cyc();
      for (int i = 0; i < 4; i++) begin
         if (i == 1) bus.note_done = 1'b1;
         set_in(0, 0, 1, 16'h5555);
         cyc();
         check("pause_rdy", 32'(bus.sample_out_ready), 32'd0);
         check("pause_st", 32'(bus.env_state), 32'd1);
      end
      set_in(1, 0, 0, 16'h0);
      cyc();
      check("resume_rdy", 32'(bus.sample_out_ready), 32'd1);
      check("resume_rel", 32'(bus.env_state), 32'd4);
      cyc();
      check("resume_once", 32'(bus.sample_out_ready), 32'd0);

      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 39) == 0) bus.note_done = ~bus.note_done;
         set_in($urandom_range(0, 9) != 0, $urandom_range(0, 99) == 0,
                $urandom_range(0, 3) != 0, 16'($urandom));
         cyc();
      end

      // mid-note reset with a sample in flight
      set_in(1, 1, 0, 16'h0);
      cyc();
      ticks(10);
      reset = 1'b1;
      set_in(1, 0, 1, 16'h4000);
      cyc();
      check("mid_rst_env", 32'(bus.envelope), 32'd0);
      check("mid_rst_st", 32'(bus.env_state), 32'd0);
      reset = 1'b0;
      set_in(1, 0, 0, 16'h0);
      cyc();
      check("mid_rst_rdy", 32'(bus.sample_out_ready), 32'd0);
      check("mid_rst_out", 32'(bus.sample_out), 32'd0);

      // gain 1 on a one-step-attack instance
      reset1 = 1'b0;
      bus1.note_start = 1'b1;
      step1();
      bus1.note_start = 1'b0;
      bus1.sample_in = 16'hFFFF;
      bus1.sample_in_ready = 1'b1;
      step1();
      step1();
      check("g1_gain", 32'(bus1.envelope), 32'd2);
      bus1.sample_in_ready = 1'b0;
      check("g0_out", 32'(bus1.sample_out), 32'd0);
      step1();
      check("g1_rdy", 32'(bus1.sample_out_ready), 32'd1);
      check("g1_out", 32'(bus1.sample_out), 32'h0000FFFF);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
